// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter
//   Shares one SPI master between NREQ clients. A round-robin pick loads the
//   winner's word onto the master data input, issues a one-cycle start, follows
//   the master busy window, pulses a one-hot ack (with err on start timeout) and
//   then holds an idle gap before the next arbitration.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req[NREQ]             per-client request levels
//   req_data[NREQ*DW]     per-client words, slice i = req_data[i*DW +: DW]
//   ack[NREQ], err        one-cycle completion pulse, err = master never went busy
//   grant[NREQ]           one-hot owner of the current transaction, 0 when idle
//   mst_start, mst_data   start strobe and registered word to the SPI master
//   mst_busy              master transfer in progress
//   arb_busy              high whenever the arbiter is not idle
module spi_txn_arbiter #(
  parameter int NREQ       = 4,
  parameter int DW         = 16,
  parameter int START_TO   = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    ack,
  output logic               err,
  output logic [NREQ-1:0]    grant,
  output logic               mst_start,
  output logic [DW-1:0]      mst_data,
  input  logic               mst_busy,
  output logic               arb_busy
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(START_TO);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_GAP       = 3'd4
  } state_t;

  function automatic logic [NREQ-1:0] onehot(input logic [LW-1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [GW-1:0]   gap_r, gap_nxt_s;
  logic [LW-1:0]   last_r, last_nxt_s;
  logic [NREQ-1:0] grant_r, grant_nxt_s;
  logic [NREQ-1:0] ack_r, ack_nxt_s;
  logic            err_r, err_nxt_s;
  logic            start_r, start_nxt_s;
  logic [DW-1:0]   data_r, data_nxt_s;
  logic            arb_busy_r, arb_busy_nxt_s;

  logic            win_found_s;
  logic [LW-1:0]   win_idx_s;
  logic [LW-1:0]   scan_s;
  logic [DW-1:0]   win_data_s;

  // Round-robin scan starting one past the last winner, plus the winner's word.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = '0;
    scan_s      = '0;
    win_data_s  = '0;
    for (int i = 1; i <= NREQ; i++) begin
      scan_s = LW'((int'(last_r) + i) % NREQ);
      if (!win_found_s && req[scan_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_s == LW'(i)) begin
        win_data_s = req_data[i*DW +: DW];
      end else begin
        win_data_s = win_data_s;
      end
    end
  end

  // Next-state and next-output logic; registered outputs hold unless changed.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    gap_nxt_s   = gap_r;
    last_nxt_s  = last_r;
    grant_nxt_s = grant_r;
    data_nxt_s  = data_r;
    ack_nxt_s   = '0;
    err_nxt_s   = 1'b0;
    start_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          grant_nxt_s = onehot(win_idx_s);
          data_nxt_s  = win_data_s;
          last_nxt_s  = win_idx_s;
          start_nxt_s = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        cnt_nxt_s   = '0;
        state_nxt_s = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (mst_busy) begin
          state_nxt_s = ST_WAIT_DONE;
        end else if (cnt_r == CW'(START_TO - 1)) begin
          // Master never acknowledged the start: complete with error.
          ack_nxt_s   = grant_r;
          err_nxt_s   = 1'b1;
          grant_nxt_s = '0;
          gap_nxt_s   = '0;
          state_nxt_s = ST_GAP;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      ST_WAIT_DONE: begin
        // Transfer length belongs to the master, so no timeout here.
        if (!mst_busy) begin
          ack_nxt_s   = grant_r;
          grant_nxt_s = '0;
          gap_nxt_s   = '0;
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_WAIT_DONE;
        end
      end
      ST_GAP: begin
        if (gap_r == GW'(GAP_CYCLES - 1)) begin
          state_nxt_s = ST_IDLE;
        end else begin
          gap_nxt_s = gap_r + GW'(1);
        end
      end
      default: begin
        grant_nxt_s = '0;
        state_nxt_s = ST_IDLE;
      end
    endcase
    arb_busy_nxt_s = (state_nxt_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      gap_r      <= '0;
      last_r     <= LW'(NREQ - 1);
      grant_r    <= '0;
      ack_r      <= '0;
      err_r      <= 1'b0;
      start_r    <= 1'b0;
      data_r     <= '0;
      arb_busy_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      gap_r      <= gap_nxt_s;
      last_r     <= last_nxt_s;
      grant_r    <= grant_nxt_s;
      ack_r      <= ack_nxt_s;
      err_r      <= err_nxt_s;
      start_r    <= start_nxt_s;
      data_r     <= data_nxt_s;
      arb_busy_r <= arb_busy_nxt_s;
    end
  end

  assign ack       = ack_r;
  assign err       = err_r;
  assign grant     = grant_r;
  assign mst_start = start_r;
  assign mst_data  = data_r;
  assign arb_busy  = arb_busy_r;

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter: a vector table of isolated transactions
// followed by hand-written multi-cycle sequences. A small SPI master model
// raises busy one cycle after it sees the start strobe, for busy_len cycles.
module tb_spi_txn_arbiter;
  localparam int NREQ       = 4;
  localparam int DW         = 16;
  localparam int START_TO   = 8;
  localparam int GAP_CYCLES = 2;

  logic               clk = 1'b0;
  logic               reset;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    ack;
  logic               err;
  logic [NREQ-1:0]    grant;
  logic               mst_start;
  logic [DW-1:0]      mst_data;
  logic               mst_busy;
  logic               arb_busy;

  logic stuck;
  int   busy_len;
  int   bcnt = 0;
  logic pend = 1'b0;
  int   cyc  = 0;
  int   n_vec = 0;
  int   n_err = 0;

  typedef struct {
    logic [3:0]  req;
    logic [63:0] data;
    int          busy;
    logic [3:0]  exp_grant;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;
  vec_t vecs[7];

  spi_txn_arbiter #(
    .NREQ(NREQ), .DW(DW), .START_TO(START_TO), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
    .err(err), .grant(grant), .mst_start(mst_start), .mst_data(mst_data),
    .mst_busy(mst_busy), .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  // Free-running cycle counter for spacing measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model: start seen -> busy for busy_len cycles one cycle later.
  always @(posedge clk) begin
    if (reset) begin
      pend <= 1'b0;
      bcnt <= 0;
    end else begin
      pend <= mst_start && (busy_len > 0);
      if (pend) bcnt <= busy_len;
      else if (bcnt > 0) bcnt <= bcnt - 1;
    end
  end
  assign mst_busy = stuck || (bcnt != 0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic wait_start(input int lim, output bit got);
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (mst_start === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ack(input int lim, output int lat, output int extra);
    lat   = 0;
    extra = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      lat++;
      if (mst_start === 1'b1) extra++;
      if (ack !== '0) break;
    end
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (arb_busy !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(arb_busy), 64'd0);
  endtask

  initial begin
    bit          got;
    int          lat, extra, prev_c, start_c, quiet;
    logic [3:0]  one_k;
    logic [15:0] word_k;

    vecs[0] = '{4'b0001, 64'h0000_0000_0000_A569, 32, 4'b0001, 16'hA569, 1'b0, 35};
    vecs[1] = '{4'b0010, 64'h0000_0000_BEEF_0000,  0, 4'b0010, 16'hBEEF, 1'b1,  9};
    vecs[2] = '{4'b1111, 64'h4444_3333_2222_1111,  3, 4'b0100, 16'h3333, 1'b0,  6};
    vecs[3] = '{4'b1011, 64'hD00D_C00C_B00B_A00A,  1, 4'b1000, 16'hD00D, 1'b0,  4};
    vecs[4] = '{4'b0101, 64'h0000_5A5A_0000_1234,  5, 4'b0001, 16'h1234, 1'b0,  8};
    vecs[5] = '{4'b1100, 64'hFFFF_8001_0000_0000,  2, 4'b0100, 16'h8001, 1'b0,  5};
    vecs[6] = '{4'b1001, 64'h7777_0000_0000_0001,  0, 4'b1000, 16'h7777, 1'b1,  9};

    reset = 1'b1; req = '0; req_data = '0; stuck = 1'b0; busy_len = 0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_start", 64'(mst_start), 64'd0);
    chk("rst_data", 64'(mst_data), 64'd0);
    chk("rst_arb_busy", 64'(arb_busy), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Table: isolated transactions, round-robin pointer carried across them.
    for (int v = 0; v < 7; v++) begin
      req = vecs[v].req; req_data = vecs[v].data; busy_len = vecs[v].busy;
      @(negedge clk);
      chk("start_latency", 64'(mst_start), 64'd1);
      chk("grant", 64'(grant), 64'(vecs[v].exp_grant));
      chk("mst_data", 64'(mst_data), 64'(vecs[v].exp_data));
      chk("arb_busy", 64'(arb_busy), 64'd1);
      wait_ack(100, lat, extra);
      chk("ack", 64'(ack), 64'(vecs[v].exp_grant));
      chk("err", 64'(err), 64'(vecs[v].exp_err));
      chk("ack_latency", 64'(lat), 64'(vecs[v].exp_lat));
      chk("grant_clear", 64'(grant), 64'd0);
      chk("no_restart", 64'(extra), 64'd0);
      req = '0;
      @(negedge clk);
      chk("ack_one_cycle", 64'({ack, err}), 64'd0);
      @(negedge clk);
      chk("arb_idle_after_gap", 64'(arb_busy), 64'd0);
      chk("data_hold", 64'(mst_data), 64'(vecs[v].exp_data));
    end

    // All four at once, each dropping on its ack.
    pulse_reset();
    req_data = 64'h4444_3333_2222_1111; busy_len = 4; req = 4'b1111;
    prev_c = 0;
    for (int k = 0; k < 4; k++) begin
      one_k  = 4'b0001 << k;
      word_k = 16'h1111 * 16'(k + 1);
      wait_start(60, got);
      chk("A_start_seen", 64'(got), 64'd1);
      start_c = cyc;
      if (k > 0) chk("A_spacing", 64'((start_c - prev_c) >= (4 + GAP_CYCLES + 4)), 64'd1);
      prev_c = start_c;
      chk("A_grant", 64'(grant), 64'(one_k));
      chk("A_data", 64'(mst_data), 64'(word_k));
      wait_ack(60, lat, extra);
      chk("A_ack", 64'(ack), 64'(one_k));
      req[k] = 1'b0;
    end
    quiet = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mst_start === 1'b1 || ack !== '0) quiet++;
    end
    chk("A_no_fifth_txn", 64'(quiet), 64'd0);

    // Fairness: clients 2 and 3 re-request right after each ack.
    pulse_reset();
    req_data = 64'h0B0B_0A0A_0000_0000; busy_len = 2; req = 4'b1100;
    for (int k = 0; k < 4; k++) begin
      one_k = (k % 2 == 0) ? 4'b0100 : 4'b1000;
      wait_start(60, got);
      chk("B_start_seen", 64'(got), 64'd1);
      chk("B_grant", 64'(grant), 64'(one_k));
      wait_ack(60, lat, extra);
      chk("B_ack", 64'(ack), 64'(one_k));
      req = req & ~one_k;
      @(negedge clk);
      req = req | one_k;
    end
    req = '0;
    wait_idle(20);

    // Reset during WAIT_DONE with client 1 granted.
    pulse_reset();
    req_data = 64'h0000_0000_CAFE_0000; busy_len = 20; req = 4'b0010;
    wait_start(10, got);
    chk("C_start_seen", 64'(got), 64'd1);
    repeat (6) @(negedge clk);
    chk("C_grant_mid", 64'(grant), 64'b0010);
    chk("C_busy_mid", 64'(mst_busy), 64'd1);
    reset = 1'b1; req = '0;
    @(negedge clk);
    chk("C_rst_outputs", 64'({grant, ack, err, mst_start, mst_data, arb_busy}), 64'd0);
    reset = 1'b0;
    quiet = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (mst_start === 1'b1 || ack !== '0) quiet++;
    end
    chk("C_no_ack_after_abort", 64'(quiet), 64'd0);
    req_data = 64'h4444_3333_2222_1111; req = 4'b1111;
    @(negedge clk);
    chk("C_rearb_start", 64'(mst_start), 64'd1);
    chk("C_rearb_grant", 64'(grant), 64'b0001);
    chk("C_rearb_data", 64'(mst_data), 64'h1111);
    req = '0;
    wait_ack(60, lat, extra);
    chk("C_rearb_ack", 64'(ack), 64'b0001);
    wait_idle(20);

    // Master already busy before start: start still issued, no timeout.
    stuck = 1'b1; busy_len = 0;
    req_data = 64'h0000_3C3C_0000_0000; req = 4'b0100;
    @(negedge clk);
    chk("D_start", 64'(mst_start), 64'd1);
    chk("D_grant", 64'(grant), 64'b0100);
    req = '0;
    quiet = 0;
    for (int i = 0; i < START_TO + 4; i++) begin
      @(negedge clk);
      if (ack !== '0 || err !== 1'b0) quiet++;
    end
    chk("D_no_ack_while_busy", 64'(quiet), 64'd0);
    stuck = 1'b0;
    @(negedge clk);
    chk("D_ack", 64'(ack), 64'b0100);
    chk("D_err", 64'(err), 64'd0);
    wait_idle(20);

    // Client drops req right after grant.
    busy_len = 20; req_data = 64'h9999_0000_0000_0000; req = 4'b1000;
    @(negedge clk);
    chk("E_start", 64'(mst_start), 64'd1);
    chk("E_grant", 64'(grant), 64'b1000);
    req = '0;
    wait_ack(60, lat, extra);
    chk("E_ack", 64'(ack), 64'b1000);
    chk("E_err", 64'(err), 64'd0);
    chk("E_latency", 64'(lat), 64'd23);
    chk("E_single_start", 64'(extra), 64'd0);
    quiet = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mst_start === 1'b1) quiet++;
    end
    chk("E_no_second_start", 64'(quiet), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end
endmodule
